// File: rtl/wfg_wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module   : wfg_wishbone_master
//  Brief    : Single-outstanding Wishbone classic master. Turns one
//             valid/ready command into one bus cycle and returns the read
//             data, or a timeout error, on a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module wfg_wishbone_master #(
   parameter int BUSW    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   // command channel
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [BUSW-1:0]     cmd_adr_i,
   input  logic [BUSW-1:0]     cmd_dat_i,
   input  logic [BUSW/8-1:0]   cmd_sel_i,
   // response channel
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [BUSW-1:0]     rsp_dat_o,
   output logic                rsp_err_o,
   // Wishbone master side
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [BUSW-1:0]     wbm_adr_o,
   output logic [BUSW-1:0]     wbm_dat_o,
   output logic [BUSW/8-1:0]   wbm_sel_o,
   input  logic [BUSW-1:0]     wbm_dat_i,
   input  logic                wbm_ack_i
);

   // Last counter value before the cycle is abandoned.
   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [7:0]         r_cnt;
   logic               r_we;
   logic [BUSW-1:0]    r_adr;
   logic [BUSW-1:0]    r_dat;
   logic [BUSW/8-1:0]  r_sel;
   logic [BUSW-1:0]    r_rsp_dat;
   logic               r_rsp_err;
   logic               w_in_bus;
   logic               w_timeout;

   assign w_in_bus  = (r_state == BUS);
   assign w_timeout = (r_cnt == C_TO_LAST);

   // State register; asynchronous reset drops the bus cycle immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; ack takes priority over the timeout condition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (cmd_valid_i) w_state_nxt = BUS;
         BUS:     if (wbm_ack_i || w_timeout) w_state_nxt = RESP;
         RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Command capture, timeout counting and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= 8'd0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_rsp_dat <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid_i) begin
                  r_we  <= cmd_we_i;
                  r_adr <= cmd_adr_i;
                  r_dat <= cmd_dat_i;
                  r_sel <= cmd_sel_i;
                  r_cnt <= 8'd0;
               end
            end
            BUS: begin
               if (wbm_ack_i) begin
                  r_rsp_dat <= r_we ? '0 : wbm_dat_i;
                  r_rsp_err <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp_dat <= '0;
                  r_rsp_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               // RESP: response registers hold until consumed.
            end
         endcase
      end
   end

   // Ready only in IDLE and only once reset has been released.
   assign cmd_ready_o = (r_state == IDLE) && rst_n;
   assign rsp_valid_o = (r_state == RESP);
   assign rsp_dat_o   = r_rsp_dat;
   assign rsp_err_o   = r_rsp_err;

   assign wbm_cyc_o   = w_in_bus;
   assign wbm_stb_o   = w_in_bus;
   assign wbm_we_o    = r_we && w_in_bus;
   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;
   assign wbm_sel_o   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_wfg_wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wfg_wishbone_master
//  Brief    : Self-checking bench for wfg_wishbone_master with a register-file
//             slave, a reference memory model and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wfg_wishbone_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc, wbm_stb, wbm_we, wb_ack;
   logic [31:0] wbm_adr, wbm_dat, wb_dat;
   logic [3:0]  wbm_sel;

   int checks = 0;
   int fails  = 0;
   int cyc_cnt = 0;
   int last_acc = 0;
   int stb_run = 0;
   logic prev_valid = 1'b0;
   logic slave_en = 1'b1;

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;
   exp_t q[$];

   logic [31:0] model_mem [16];
   logic [31:0] slave_mem [16];
   logic        cur_we;
   logic [31:0] cur_adr, cur_dat;
   logic [3:0]  cur_sel;

   wfg_wishbone_master #(.BUSW(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
      .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
      .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
      .wbm_dat_i(wb_dat), .wbm_ack_i(wb_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register-file slave with registered ack; ack lingers one cycle after stb.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack <= 1'b0;
         wb_dat <= '0;
      end else begin
         wb_ack <= slave_en & wbm_cyc & wbm_stb;
         if (slave_en && wbm_cyc && wbm_stb) begin
            wb_dat <= slave_mem[wbm_adr[3:0]];
            if (wbm_we)
               for (int b = 0; b < 4; b++)
                  if (wbm_sel[b]) slave_mem[wbm_adr[3:0]][8*b +: 8] <= wbm_dat[8*b +: 8];
         end
      end
   end

   // Monitor: bus-side rules, latency and the response scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!wbm_stb) check("we_without_stb", {31'd0, wbm_we}, 32'd0);
         if (wbm_stb) begin
            check("bus_adr", wbm_adr, cur_adr);
            check("bus_dat", wbm_dat, cur_dat);
            check("bus_sel", {28'd0, wbm_sel}, {28'd0, cur_sel});
            check("bus_we", {31'd0, wbm_we}, {31'd0, cur_we});
            check("ready_in_bus", {31'd0, cmd_ready}, 32'd0);
            stb_run++;
         end else if (stb_run > 0) begin
            if (q.size() > 0) check("stb_cycles", stb_run, q[0].lat);
            stb_run = 0;
         end
         if (rsp_valid) check("ready_in_resp", {31'd0, cmd_ready}, 32'd0);
         if (rsp_valid && !prev_valid) begin
            if (q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else check("rsp_latency", cyc_cnt - q[0].acc, q[0].lat);
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               check("rsp_dat", rsp_dat, e.dat);
               check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
         end
         prev_valid = rsp_valid;
      end else begin
         stb_run = 0;
         prev_valid = 1'b0;
      end
   end

   // Issue one command and record the model's expected response.
   task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      exp_t e;
      w = 0;
      cmd_we = we; cmd_adr = {28'd0, a}; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cur_we = we; cur_adr = {28'd0, a}; cur_dat = d; cur_sel = s;
      e.acc = cyc_cnt;
      if (slave_en) begin
         e.err = 1'b0;
         e.lat = 2;
         if (we) begin
            e.dat = '0;
            for (int b = 0; b < 4; b++)
               if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
         end else begin
            e.dat = model_mem[a];
         end
      end else begin
         e.err = 1'b1;
         e.dat = '0;
         e.lat = TO;
      end
      q.push_back(e);
      last_acc = e.acc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("drain", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = '0;
         slave_mem[i] = '0;
      end
      model_mem[15] = 32'h0000_0101;
      slave_mem[15] = 32'h0000_0101;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
      check("rst_stb", {31'd0, wbm_stb}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'd0);
      check("rst_adr", wbm_adr, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Read of preset register, write then read-back
      send(1'b0, 4'hF, $urandom, 4'hF);
      wait_idle();
      send(1'b1, 4'h2, 32'h0000_0C35, 4'hF);
      wait_idle();
      send(1'b0, 4'h2, 32'h0, 4'hF);
      wait_idle();

      // Timeout: silent slave
      slave_en = 1'b0;
      send(1'b0, 4'h5, 32'h0, 4'hF);
      wait_idle();
      slave_en = 1'b1;

      // Backpressure with a pending second command
      rsp_ready = 1'b0;
      send(1'b0, 4'h2, 32'h0, 4'hF);
      begin
         int w;
         w = 0;
         while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
         end
      end
      cmd_we = 1'b1; cmd_adr = 32'h3; cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF; cmd_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", {31'd0, rsp_valid}, 32'd1);
         if (q.size() > 0) begin
            check("bp_dat", rsp_dat, q[0].dat);
            check("bp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
         end
         check("bp_no_stb", {31'd0, wbm_stb}, 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      wait_idle();

      // Reset while the bus cycle is active
      send(1'b0, 4'h7, 32'h0, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      check("rstbus_cyc", {31'd0, wbm_cyc}, 32'd0);
      check("rstbus_stb", {31'd0, wbm_stb}, 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("rstbus_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Back-to-back random traffic
      for (int i = 0; i < 8; i++) begin
         prev = last_acc;
         send(1'($urandom % 2), 4'($urandom % 16), $urandom, 4'($urandom % 16));
         if (i > 0) check("b2b_interval", last_acc - prev, 4);
      end
      wait_idle();
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 4'(i), 32'h0, 4'hF);
      end
      wait_idle();

      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
